full_adder_checker: RTL and testbench

//   Sequential response checker for the my_full_adder datapath: the receiving end of the

---
 rtl/full_adder_checker.sv | 190 +++++++++++++++++++
 tb/tb_full_adder_checker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_checker.sv
// ----------------------------------------------------------------------------
// full_adder_checker
//
// Sequential response checker for a single-bit full adder. Each accepted
// vector carries the adder inputs {a,b,c} together with the sum/carry the
// adder under test produced. The checker recomputes the golden result,
// counts passes and fails, remembers the first mismatch of the session and
// raises a verdict once NUM_VECTORS vectors have been accepted.
//
// Optional feature macro: FA_CHK_COVERAGE_EN
//   When defined, adds out_coverage[7:0] (bit k set once {a,b,c}==k has been
//   accepted this session) and requires full coverage for out_all_pass.
//
// Parameters
//   NUM_VECTORS         vectors per session (1 .. 2**CNT_W-1)
//   CNT_W               width of index and pass/fail counters
//
// Ports
//   clk                 single clock, rising edge
//   reset               synchronous, active-high
//   in_start            start or restart a session (single-cycle pulse)
//   in_valid            observed vector present this cycle
//   in_a/in_b/in_c      adder inputs as applied
//   in_sum/in_carry     adder outputs as observed
//   out_ready           vector accepted this cycle when in_valid is high
//   out_busy            session in progress
//   out_done            session complete, verdict valid
//   out_all_pass        done with zero fails (and full coverage if enabled)
//   out_pass_cnt        matching vectors (saturating)
//   out_fail_cnt        mismatching vectors (saturating)
//   out_first_fail_idx  accept index of the first mismatch
//   out_first_fail_vec  {a,b,c,sum,carry} of the first mismatch
//   out_coverage        (FA_CHK_COVERAGE_EN only) input-combination coverage
// ----------------------------------------------------------------------------
module full_adder_checker #(
   parameter int NUM_VECTORS = 8,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_start,
   input  logic             in_valid,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             in_c,
   input  logic             in_sum,
   input  logic             in_carry,
   output logic             out_ready,
   output logic             out_busy,
   output logic             out_done,
   output logic             out_all_pass,
   output logic [CNT_W-1:0] out_pass_cnt,
   output logic [CNT_W-1:0] out_fail_cnt,
   output logic [CNT_W-1:0] out_first_fail_idx,
   output logic [4:0]       out_first_fail_vec
`ifdef FA_CHK_COVERAGE_EN
   ,
   output logic [7:0]       out_coverage
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] idx_q;
   logic [CNT_W-1:0] pass_q;
   logic [CNT_W-1:0] fail_q;
   logic [CNT_W-1:0] first_idx_q;
   logic [4:0]       first_vec_q;
   logic             accept;
   logic             exp_sum;
   logic             exp_carry;
   logic             match;
   logic             cov_ok;

   // A start pulse always wins over a simultaneous vector, so the vector
   // offered in the same cycle as a restart is dropped.
   assign accept = (state_q == RUN) & in_valid & ~in_start;

   // Golden full-adder result for the offered inputs.
   assign exp_sum   = in_a ^ in_b ^ in_c;
   assign exp_carry = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
   assign match     = (in_sum == exp_sum) & (in_carry == exp_carry);

`ifdef FA_CHK_COVERAGE_EN
   logic [7:0] cov_q;

   // Coverage bitmap: one bit per {a,b,c} combination seen this session.
   always_ff @(posedge clk) begin
      if (reset) begin
         cov_q <= '0;
      end else if (in_start) begin
         cov_q <= '0;
      end else if (accept) begin
         cov_q[{in_a, in_b, in_c}] <= 1'b1;
      end
   end

   assign out_coverage = cov_q;
   assign cov_ok       = (cov_q == 8'hFF);
`else
   assign cov_ok = 1'b1;
`endif

   // State register; reset takes priority over any start request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs. A start from any state (including a
   // restart while running) lands in RUN; the counter block clears alongside.
   always_comb begin
      state_d   = state_q;
      out_ready = 1'b0;
      out_busy  = 1'b0;
      out_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            out_ready = 1'b1;
            out_busy  = 1'b1;
            if (in_start) begin
               state_d = RUN;
            end else if (accept && (idx_q == LAST_IDX)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_done = 1'b1;
            if (in_start) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Session bookkeeping. Counters saturate rather than wrap, and the
   // first-fail record is captured only while the fail count is still zero,
   // which is exactly the first mismatch of the session.
   always_ff @(posedge clk) begin
      if (reset || in_start) begin
         idx_q       <= '0;
         pass_q      <= '0;
         fail_q      <= '0;
         first_idx_q <= '0;
         first_vec_q <= '0;
      end else if (accept) begin
         idx_q <= idx_q + 1'b1;
         if (match) begin
            if (pass_q != CNT_MAX) begin
               pass_q <= pass_q + 1'b1;
            end
         end else begin
            if (fail_q != CNT_MAX) begin
               fail_q <= fail_q + 1'b1;
            end
            if (fail_q == '0) begin
               first_idx_q <= idx_q;
               first_vec_q <= {in_a, in_b, in_c, in_sum, in_carry};
            end
         end
      end
   end

   assign out_all_pass       = (state_q == DONE) & (fail_q == '0) & cov_ok;
   assign out_pass_cnt       = pass_q;
   assign out_fail_cnt       = fail_q;
   assign out_first_fail_idx = first_idx_q;
   assign out_first_fail_vec = first_vec_q;

endmodule

// File: tb/tb_full_adder_checker.sv
// ----------------------------------------------------------------------------
// tb_full_adder_checker
//
// Self-checking bench for full_adder_checker (NUM_VECTORS=8, CNT_W=4).
// A behavioural model tracks the session with plain integer arithmetic and
// every output is compared against it one time unit after each clock edge.
// Hand-written sequences cover the directed scenarios; a randomized phase
// exercises gaps, injected errors and mid-session restarts.
// ----------------------------------------------------------------------------
module tb_full_adder_checker;

   logic       clk;
   logic       reset;
   logic       in_start;
   logic       in_valid;
   logic       in_a;
   logic       in_b;
   logic       in_c;
   logic       in_sum;
   logic       in_carry;
   logic       out_ready;
   logic       out_busy;
   logic       out_done;
   logic       out_all_pass;
   logic [3:0] out_pass_cnt;
   logic [3:0] out_fail_cnt;
   logic [3:0] out_first_fail_idx;
   logic [4:0] out_first_fail_vec;
`ifdef FA_CHK_COVERAGE_EN
   logic [7:0] out_coverage;
`endif

   full_adder_checker #(.NUM_VECTORS(8), .CNT_W(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .in_start           (in_start),
      .in_valid           (in_valid),
      .in_a               (in_a),
      .in_b               (in_b),
      .in_c               (in_c),
      .in_sum             (in_sum),
      .in_carry           (in_carry),
      .out_ready          (out_ready),
      .out_busy           (out_busy),
      .out_done           (out_done),
      .out_all_pass       (out_all_pass),
      .out_pass_cnt       (out_pass_cnt),
      .out_fail_cnt       (out_fail_cnt),
      .out_first_fail_idx (out_first_fail_idx),
      .out_first_fail_vec (out_first_fail_vec)
`ifdef FA_CHK_COVERAGE_EN
      ,
      .out_coverage       (out_coverage)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   // Behavioural model: 0 idle, 1 running, 2 done.
   int         m_state;
   int         m_acc;
   int         m_pass;
   int         m_fail;
   int         m_fidx;
   logic [4:0] m_fvec;
   logic [7:0] m_cov;

   typedef struct {
      logic [2:0] abc;
      logic       sum;
      logic       carry;
      logic       exp_match;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic modelClear();
      m_acc  = 0;
      m_pass = 0;
      m_fail = 0;
      m_fidx = 0;
      m_fvec = '0;
      m_cov  = '0;
   endtask

   task automatic modelStep(input logic start, input logic valid, input logic [2:0] abc,
                            input logic sum, input logic carry);
      int  total;
      bit  ok;
      if (start) begin
         modelClear();
         m_state = 1;
      end else if (m_state == 1 && valid) begin
         total = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
         ok    = (int'(sum) == total % 2) && (int'(carry) == total / 2);
         if (ok) begin
            m_pass = (m_pass < 15) ? m_pass + 1 : 15;
         end else begin
            if (m_fail == 0) begin
               m_fidx = m_acc;
               m_fvec = {abc, sum, carry};
            end
            m_fail = (m_fail < 15) ? m_fail + 1 : 15;
         end
         m_cov[abc] = 1'b1;
         m_acc++;
         if (m_acc == 8) m_state = 2;
      end
   endtask

   task automatic applyStimulus(input logic start, input logic valid, input logic [2:0] abc,
                                input logic sum, input logic carry);
      in_start = start;
      in_valid = valid;
      {in_a, in_b, in_c} = abc;
      in_sum   = sum;
      in_carry = carry;
      modelStep(start, valid, abc, sum, carry);
      @(posedge clk);
      #1;
      in_start = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      m_state = 0;
      modelClear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Correct adder response for abc, optionally corrupted in the sum bit
   // (bad=1) or the carry bit (bad=2).
   task automatic sendVec(input logic [2:0] abc, input int bad);
      int   total;
      logic s;
      logic c;
      total = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
      s = logic'(total % 2);
      c = logic'(total / 2);
      if (bad == 1) s = ~s;
      if (bad == 2) c = ~c;
      applyStimulus(1'b0, 1'b1, abc, s, c);
   endtask

   task automatic checkOutput(input string tag);
      logic exp_all;
      exp_all = (m_state == 2) && (m_fail == 0);
`ifdef FA_CHK_COVERAGE_EN
      exp_all = exp_all && (m_cov == 8'hFF);
      check({tag, ".coverage"}, int'(out_coverage), int'(m_cov));
`endif
      check({tag, ".ready"}, int'(out_ready), int'(m_state == 1));
      check({tag, ".busy"}, int'(out_busy), int'(m_state == 1));
      check({tag, ".done"}, int'(out_done), int'(m_state == 2));
      check({tag, ".all_pass"}, int'(out_all_pass), int'(exp_all));
      check({tag, ".pass_cnt"}, int'(out_pass_cnt), m_pass);
      check({tag, ".fail_cnt"}, int'(out_fail_cnt), m_fail);
      check({tag, ".first_idx"}, int'(out_first_fail_idx), m_fidx);
      check({tag, ".first_vec"}, int'(out_first_fail_vec), int'(m_fvec));
   endtask

   initial begin
      vec_t tbl[8];
      int   tbl_pass;

      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      in_start = 1'b0;
      in_valid = 1'b0;
      in_a     = 1'b0;
      in_b     = 1'b0;
      in_c     = 1'b0;
      in_sum   = 1'b0;
      in_carry = 1'b0;

      tbl[0] = '{3'd0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{3'd1, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{3'd2, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{3'd3, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{3'd4, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{3'd5, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{3'd6, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{3'd7, 1'b1, 1'b1, 1'b1};

      // Reset state.
      applyReset();
      applyReset();
      checkOutput("reset");

      // Exhaustive correct session, valid every cycle.
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      checkOutput("t1.start");
      for (int k = 0; k < 8; k++) begin
         sendVec(3'(k), 0);
         checkOutput("t1.vec");
      end
      check("t1.pass8", int'(out_pass_cnt), 8);
      check("t1.done_hold", int'(out_done), 1);
`ifndef FA_CHK_COVERAGE_EN
      check("t1.all_pass", int'(out_all_pass), 1);
`endif

      // Table-driven session with vector 5 corrupted.
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      tbl_pass = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, tbl[i].abc, tbl[i].sum, tbl[i].carry);
         if (tbl[i].exp_match) tbl_pass++;
         check("t2.tbl_pass", int'(out_pass_cnt), tbl_pass);
         checkOutput("t2.vec");
      end
      check("t2.fail", int'(out_fail_cnt), 1);
      check("t2.first_idx", int'(out_first_fail_idx), 5);
      check("t2.first_vec", int'(out_first_fail_vec), 5'b10111);
      check("t2.all_pass", int'(out_all_pass), 0);

      // Fails at index 2 and 6; first-fail record stays at 2.
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         sendVec(3'(k), (k == 2) ? 2 : ((k == 6) ? 1 : 0));
         checkOutput("t3.vec");
      end
      check("t3.fail", int'(out_fail_cnt), 2);
      check("t3.first_idx", int'(out_first_fail_idx), 2);

      // Gaps between vectors, then stray valids in DONE and IDLE.
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
         checkOutput("t4.gap");
         sendVec(3'(k), 0);
         checkOutput("t4.vec");
      end
      for (int k = 0; k < 3; k++) begin
         sendVec(3'(k), 1);
         checkOutput("t4.done_valid");
      end
      check("t4.pass_hold", int'(out_pass_cnt), 8);
      applyReset();
      for (int k = 0; k < 3; k++) begin
         sendVec(3'(k), 1);
         checkOutput("t4.idle_valid");
      end

      // Start and valid together at index 3, then reset at index 4.
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) sendVec(3'(k), 0);
      applyStimulus(1'b1, 1'b1, 3'd5, 1'b1, 1'b1);
      checkOutput("t5.restart");
      check("t5.restart_pass", int'(out_pass_cnt), 0);
      check("t5.restart_fail", int'(out_fail_cnt), 0);
      for (int k = 0; k < 7; k++) sendVec(3'(k), 0);
      check("t5.not_done7", int'(out_done), 0);
      sendVec(3'd7, 0);
      check("t5.done8", int'(out_done), 1);
      checkOutput("t5.end");
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) sendVec(3'(k), (k == 1) ? 1 : 0);
      reset    = 1'b1;
      in_start = 1'b1;
      m_state  = 0;
      modelClear();
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_start = 1'b0;
      checkOutput("t5.reset_mid");
      check("t5.reset_busy", int'(out_busy), 0);

`ifdef FA_CHK_COVERAGE_EN
      // Coverage: all-zero inputs then the exhaustive set.
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) sendVec(3'd0, 0);
      check("t6.cov01", int'(out_coverage), 8'h01);
      check("t6.all_pass0", int'(out_all_pass), 0);
      checkOutput("t6.zeros");
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) sendVec(3'(k), 0);
      check("t6.covFF", int'(out_coverage), 8'hFF);
      check("t6.all_pass1", int'(out_all_pass), 1);
`endif

      // Randomized sessions with gaps, injected errors and rare restarts.
      for (int s = 0; s < 25; s++) begin
         applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
         checkOutput("rnd.start");
         for (int n = 0; n < 60 && m_state == 1; n++) begin
            if ($urandom_range(0, 39) == 0) begin
               applyStimulus(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
            end else if ($urandom_range(0, 3) == 0) begin
               applyStimulus(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b1);
            end else begin
               sendVec(3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            checkOutput("rnd.step");
         end
         check("rnd.session_done", int'(out_done), 1);
         sendVec(3'($urandom_range(0, 7)), 1);
         checkOutput("rnd.after_done");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
